// File: rtl/scl_bits_frame_counter_pkg.sv
// ---------------------------------------------------------------------------
// scl_bits_frame_counter_pkg
// Shared constants and helpers for the I3C SDR timing core.
//   - SCL mode encodings (push-pull / open-drain)
//   - command attribute encodings (regular / immediate)
//   - bits per SDR frame and the immediate-command byte cap
//   - frame_target(): number of frames a command will occupy
// ---------------------------------------------------------------------------
package scl_bits_frame_counter_pkg;

   localparam logic MODE_PP = 1'b1;
   localparam logic MODE_OD = 1'b0;

   typedef enum logic {
      CMD_REGULAR   = 1'b0,
      CMD_IMMEDIATE = 1'b1
   } cmd_attr_e;

   localparam int BITS_PER_FRAME = 9;
   localparam int MAX_IMM_BYTES  = 4;
   localparam int FRAME_W        = 17;
   localparam int PHASE_W        = 8;

   // Frames for one command: data bytes (capped for immediate commands),
   // plus one frame for the CCC code byte when the CCC is broadcast.
   // The result is one bit wider than DATA_LEN so 0xFFFF + 1 cannot wrap.
   function automatic logic [FRAME_W-1:0] frame_target(
      input logic        cmd_attr,
      input logic [15:0] data_len,
      input logic [2:0]  dtt,
      input logic        direct_broadcast_n
   );
      logic [FRAME_W-1:0] base;
      if (cmd_attr == CMD_IMMEDIATE) begin
         if (int'(dtt) > MAX_IMM_BYTES) begin
            base = FRAME_W'(MAX_IMM_BYTES);
         end else begin
            base = FRAME_W'(dtt);
         end
      end else begin
         base = FRAME_W'(data_len);
      end
      if (!direct_broadcast_n) begin
         base = base + FRAME_W'(1);
      end
      return base;
   endfunction

endpackage

// File: rtl/scl_bits_frame_counter_scl_generation.sv
// ---------------------------------------------------------------------------
// scl_generation
// Produces SCL from the system clock with a phase counter, plus registered
// one-cycle pulses that coincide with each SCL transition.
// Optional feature: define SCL_STALL_EN to let i_stall freeze SCL.
// Ports:
//   i_sys_clk, i_rst     clock, async active-high reset
//   i_pp_od              1 = push-pull timing, 0 = open-drain timing
//   i_stall              freeze SCL and suppress pulses (SCL_STALL_EN only)
//   i_idle               force SCL high, clear phase counter
//   i_cas                tCAS wait, same effect as idle
//   o_scl                SCL level (reset 1)
//   o_pos_edge           pulse in the cycle SCL rises
//   o_neg_edge           pulse in the cycle SCL falls
//   o_neg_edge_next      combinational: a falling edge is taken on this clock
// ---------------------------------------------------------------------------
module scl_generation
   import scl_bits_frame_counter_pkg::*;
#(
   parameter int PP_LOW  = 2,
   parameter int PP_HIGH = 2,
   parameter int OD_LOW  = 6,
   parameter int OD_HIGH = 2
) (
   input  logic i_sys_clk,
   input  logic i_rst,
   input  logic i_pp_od,
   input  logic i_stall,
   input  logic i_idle,
   input  logic i_cas,
   output logic o_scl,
   output logic o_pos_edge,
   output logic o_neg_edge,
   output logic o_neg_edge_next
);

   localparam logic [PHASE_W-1:0] PP_LOW_LAST  = PHASE_W'(PP_LOW - 1);
   localparam logic [PHASE_W-1:0] PP_HIGH_LAST = PHASE_W'(PP_HIGH - 1);
   localparam logic [PHASE_W-1:0] OD_LOW_LAST  = PHASE_W'(OD_LOW - 1);
   localparam logic [PHASE_W-1:0] OD_HIGH_LAST = PHASE_W'(OD_HIGH - 1);

   logic               scl_q, scl_d;
   logic               pos_q, pos_d;
   logic               neg_q, neg_d;
   logic               mode_q, mode_d;
   logic [PHASE_W-1:0] cnt_q, cnt_d;
   logic [PHASE_W-1:0] phase_last;
   logic               stall_act;

`ifdef SCL_STALL_EN
   assign stall_act = i_stall;
`else
   logic unused_stall;
   assign unused_stall = i_stall;
   assign stall_act    = 1'b0;
`endif

   // Length of the phase in progress. The mode is latched at each phase
   // boundary so a pp/od change never stretches or cuts a running phase.
   always_comb begin
      if (mode_q == MODE_PP) begin
         phase_last = scl_q ? PP_HIGH_LAST : PP_LOW_LAST;
      end else begin
         phase_last = scl_q ? OD_HIGH_LAST : OD_LOW_LAST;
      end
   end

   // Next-state logic. Idle beats CAS beats stall beats run. Leaving idle
   // or CAS starts from a cleared counter with SCL high, so the first
   // falling edge comes a full HIGH phase later.
   always_comb begin
      scl_d  = scl_q;
      cnt_d  = cnt_q;
      mode_d = mode_q;
      pos_d  = 1'b0;
      neg_d  = 1'b0;
      if (i_idle || i_cas) begin
         scl_d  = 1'b1;
         cnt_d  = '0;
         mode_d = i_pp_od;
      end else if (stall_act) begin
         scl_d = scl_q;
      end else if (cnt_q == phase_last) begin
         cnt_d  = '0;
         scl_d  = ~scl_q;
         mode_d = i_pp_od;
         neg_d  = scl_q;
         pos_d  = ~scl_q;
      end else begin
         cnt_d = cnt_q + PHASE_W'(1);
      end
   end

   // State register; pulses are registered alongside SCL so they line up
   // with the SCL transition they mark.
   always_ff @(posedge i_sys_clk or posedge i_rst) begin
      if (i_rst) begin
         scl_q  <= 1'b1;
         cnt_q  <= '0;
         mode_q <= MODE_PP;
         pos_q  <= 1'b0;
         neg_q  <= 1'b0;
      end else begin
         scl_q  <= scl_d;
         cnt_q  <= cnt_d;
         mode_q <= mode_d;
         pos_q  <= pos_d;
         neg_q  <= neg_d;
      end
   end

   assign o_scl           = scl_q;
   assign o_pos_edge      = pos_q;
   assign o_neg_edge      = neg_q;
   assign o_neg_edge_next = neg_d;

endmodule

// File: rtl/scl_bits_frame_counter.sv
// ---------------------------------------------------------------------------
// scl_bits_frame_counter
// Timing core of the I3C SDR controller: SCL generation, bit counting within
// 9-bit SDR frames, and frame counting against the command descriptor length
// with a last-frame flag for the controller FSM.
// Optional feature: define SCL_STALL_EN to honour i_scl_gen_stall.
// Ports:
//   i_sys_clk, i_rst           clock, async active-high reset
//   i_sdr_scl_gen_pp_od        1 = push-pull, 0 = open-drain
//   i_scl_gen_stall            freeze SCL (SCL_STALL_EN only)
//   i_sdr_ctrl_scl_idle        force SCL high
//   i_timer_cas                tCAS wait, SCL high
//   i_bitcnt_en                bit counter enable (low clears)
//   i_cccnt_err_rst            synchronous bit counter clear
//   i_fcnt_en                  frame counter enable (low clears)
//   i_regf_CMD_ATTR            0 = regular, 1 = immediate
//   i_regf_DATA_LEN            regular byte count
//   i_regf_DTT                 immediate byte count
//   i_direct_broadcast_n       1 = direct CCC, 0 = broadcast CCC
//   o_scl, o_scl_pos_edge, o_scl_neg_edge   SCL and edge pulses
//   o_cnt_bit_count            bit index 0..8
//   o_frcnt_toggle             pulse on frame completion
//   o_cccnt_last_frame         high during the last frame
// ---------------------------------------------------------------------------
module scl_bits_frame_counter
   import scl_bits_frame_counter_pkg::*;
#(
   parameter int PP_LOW   = 2,
   parameter int PP_HIGH  = 2,
   parameter int OD_LOW   = 6,
   parameter int OD_HIGH  = 2,
   parameter int BITS_PER_FRAME_P = BITS_PER_FRAME
) (
   input  logic        i_sys_clk,
   input  logic        i_rst,
   input  logic        i_sdr_scl_gen_pp_od,
   input  logic        i_scl_gen_stall,
   input  logic        i_sdr_ctrl_scl_idle,
   input  logic        i_timer_cas,
   input  logic        i_bitcnt_en,
   input  logic        i_cccnt_err_rst,
   input  logic        i_fcnt_en,
   input  logic        i_regf_CMD_ATTR,
   input  logic [15:0] i_regf_DATA_LEN,
   input  logic [2:0]  i_regf_DTT,
   input  logic        i_direct_broadcast_n,
   output logic        o_scl,
   output logic        o_scl_pos_edge,
   output logic        o_scl_neg_edge,
   output logic [5:0]  o_cnt_bit_count,
   output logic        o_frcnt_toggle,
   output logic        o_cccnt_last_frame
);

   localparam logic [5:0] BIT_LAST = 6'(BITS_PER_FRAME_P - 1);

   logic               neg_next;
   logic               toggle_next;
   logic [5:0]         bit_cnt_q;
   logic               toggle_q;
   logic [FRAME_W-1:0] target_q;
   logic [FRAME_W-1:0] frames_done_q;
   logic               last_q;

   scl_generation #(
      .PP_LOW  (PP_LOW),
      .PP_HIGH (PP_HIGH),
      .OD_LOW  (OD_LOW),
      .OD_HIGH (OD_HIGH)
   ) u_scl_generation (
      .i_sys_clk       (i_sys_clk),
      .i_rst           (i_rst),
      .i_pp_od         (i_sdr_scl_gen_pp_od),
      .i_stall         (i_scl_gen_stall),
      .i_idle          (i_sdr_ctrl_scl_idle),
      .i_cas           (i_timer_cas),
      .o_scl           (o_scl),
      .o_pos_edge      (o_scl_pos_edge),
      .o_neg_edge      (o_scl_neg_edge),
      .o_neg_edge_next (neg_next)
   );

   // Counters advance on the same clock edge that registers the neg-edge
   // pulse, so the count, wrap and toggle are visible together with it.
   assign toggle_next = i_bitcnt_en && !i_cccnt_err_rst && neg_next &&
                        (bit_cnt_q == BIT_LAST);

   // Bit counter: one step per SCL falling edge, wrapping after the T bit.
   always_ff @(posedge i_sys_clk or posedge i_rst) begin
      if (i_rst) begin
         bit_cnt_q <= '0;
         toggle_q  <= 1'b0;
      end else if (!i_bitcnt_en || i_cccnt_err_rst) begin
         bit_cnt_q <= '0;
         toggle_q  <= 1'b0;
      end else if (neg_next) begin
         if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_q <= '0;
            toggle_q  <= 1'b1;
         end else begin
            bit_cnt_q <= bit_cnt_q + 6'd1;
            toggle_q  <= 1'b0;
         end
      end else begin
         toggle_q <= 1'b0;
      end
   end

   // Frame target is captured while the frame counter is off so that the
   // regfile fields may change under a running transfer without effect.
   always_ff @(posedge i_sys_clk or posedge i_rst) begin
      if (i_rst) begin
         target_q <= '0;
      end else if (!i_fcnt_en) begin
         target_q <= frame_target(i_regf_CMD_ATTR, i_regf_DATA_LEN,
                                  i_regf_DTT, i_direct_broadcast_n);
      end
   end

   // Completed-frame count, saturating at the target.
   always_ff @(posedge i_sys_clk or posedge i_rst) begin
      if (i_rst) begin
         frames_done_q <= '0;
      end else if (!i_fcnt_en) begin
         frames_done_q <= '0;
      end else if (toggle_next && (frames_done_q < target_q)) begin
         frames_done_q <= frames_done_q + FRAME_W'(1);
      end
   end

   // Last-frame flag, registered from frames_done. It is gated by the enable
   // at the output so it drops as soon as the frame counter is switched off.
   always_ff @(posedge i_sys_clk or posedge i_rst) begin
      if (i_rst) begin
         last_q <= 1'b0;
      end else begin
         last_q <= i_fcnt_en && (target_q != '0) &&
                   (frames_done_q >= (target_q - FRAME_W'(1)));
      end
   end

   assign o_cnt_bit_count    = bit_cnt_q;
   assign o_frcnt_toggle     = toggle_q;
   assign o_cccnt_last_frame = last_q & i_fcnt_en;

endmodule

// File: tb/tb_scl_bits_frame_counter.sv
// ---------------------------------------------------------------------------
// tb_scl_bits_frame_counter
// Directed self-checking bench for scl_bits_frame_counter. Inputs are driven
// 1 ns after each rising edge and outputs are sampled at the same point.
// Cycle index c counts rising edges after the generator is released from
// idle; with push-pull defaults falling edges land at c = 2, 6, 10, ... and
// the k-th frame toggle at c = 36k - 2.
// ---------------------------------------------------------------------------
module tb_scl_bits_frame_counter;
   import scl_bits_frame_counter_pkg::*;

   logic        i_sys_clk;
   logic        i_rst;
   logic        i_sdr_scl_gen_pp_od;
   logic        i_scl_gen_stall;
   logic        i_sdr_ctrl_scl_idle;
   logic        i_timer_cas;
   logic        i_bitcnt_en;
   logic        i_cccnt_err_rst;
   logic        i_fcnt_en;
   logic        i_regf_CMD_ATTR;
   logic [15:0] i_regf_DATA_LEN;
   logic [2:0]  i_regf_DTT;
   logic        i_direct_broadcast_n;
   logic        o_scl;
   logic        o_scl_pos_edge;
   logic        o_scl_neg_edge;
   logic [5:0]  o_cnt_bit_count;
   logic        o_frcnt_toggle;
   logic        o_cccnt_last_frame;

   int cmpCount = 0;
   int errCount = 0;

   scl_bits_frame_counter dut (
      .i_sys_clk            (i_sys_clk),
      .i_rst                (i_rst),
      .i_sdr_scl_gen_pp_od  (i_sdr_scl_gen_pp_od),
      .i_scl_gen_stall      (i_scl_gen_stall),
      .i_sdr_ctrl_scl_idle  (i_sdr_ctrl_scl_idle),
      .i_timer_cas          (i_timer_cas),
      .i_bitcnt_en          (i_bitcnt_en),
      .i_cccnt_err_rst      (i_cccnt_err_rst),
      .i_fcnt_en            (i_fcnt_en),
      .i_regf_CMD_ATTR      (i_regf_CMD_ATTR),
      .i_regf_DATA_LEN      (i_regf_DATA_LEN),
      .i_regf_DTT           (i_regf_DTT),
      .i_direct_broadcast_n (i_direct_broadcast_n),
      .o_scl                (o_scl),
      .o_scl_pos_edge       (o_scl_pos_edge),
      .o_scl_neg_edge       (o_scl_neg_edge),
      .o_cnt_bit_count      (o_cnt_bit_count),
      .o_frcnt_toggle       (o_frcnt_toggle),
      .o_cccnt_last_frame   (o_cccnt_last_frame)
   );

   // 10 ns system clock.
   initial i_sys_clk = 1'b0;
   always #5 i_sys_clk = ~i_sys_clk;

   task automatic tick();
      @(posedge i_sys_clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input int got, input int exp);
      cmpCount++;
      if (got != exp) begin
         errCount++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Park in idle with counters cleared, load the command fields, then
   // release. On return the caller is at c = 0.
   task automatic applyStimulus(input logic ppOd, input logic cmdAttr,
                                input logic [15:0] dataLen, input logic [2:0] dtt,
                                input logic dbn, input logic fcntEn);
      i_sdr_ctrl_scl_idle  = 1'b1;
      i_timer_cas          = 1'b0;
      i_scl_gen_stall      = 1'b0;
      i_bitcnt_en          = 1'b0;
      i_cccnt_err_rst      = 1'b0;
      i_fcnt_en            = 1'b0;
      i_sdr_scl_gen_pp_od  = ppOd;
      i_regf_CMD_ATTR      = cmdAttr;
      i_regf_DATA_LEN      = dataLen;
      i_regf_DTT           = dtt;
      i_direct_broadcast_n = dbn;
      tick();
      tick();
      i_sdr_ctrl_scl_idle = 1'b0;
      i_bitcnt_en         = 1'b1;
      i_fcnt_en           = fcntEn;
   endtask

   // Push-pull run with frame counting; expN is the hand-computed target.
   task automatic runFrames(input string tag, input logic cmdAttr,
                            input logic [15:0] dataLen, input logic [2:0] dtt,
                            input logic dbn, input int expN);
      int  riseCycle;
      int  endCycle;
      bit  early;
      bit  seen;
      applyStimulus(1'b1, cmdAttr, dataLen, dtt, dbn, 1'b1);
      if (expN == 0) begin
         seen = 1'b0;
         for (int c = 1; c <= 110; c++) begin
            tick();
            if (o_cccnt_last_frame) seen = 1'b1;
         end
         checkOutput({tag, "_never"}, int'(seen), 0);
      end else begin
         riseCycle = (expN == 1) ? 1 : 36 * (expN - 1) - 1;
         endCycle  = 36 * expN + 4;
         early     = 1'b0;
         for (int c = 1; c <= endCycle; c++) begin
            tick();
            if (c < riseCycle && o_cccnt_last_frame) early = 1'b1;
            if (c == riseCycle) checkOutput({tag, "_rise"}, int'(o_cccnt_last_frame), 1);
            if (c == endCycle)  checkOutput({tag, "_hold"}, int'(o_cccnt_last_frame), 1);
         end
         checkOutput({tag, "_early"}, int'(early), 0);
      end
      i_fcnt_en = 1'b0;
      #1;
      checkOutput({tag, "_en_off"}, int'(o_cccnt_last_frame), 0);
   endtask

   logic [2:0] dttList [8]  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
   int         nDirect [8]  = '{0, 1, 2, 3, 4, 4, 4, 4};
   int         nBcast  [8]  = '{1, 2, 3, 4, 5, 5, 5, 5};

   initial begin
      int m;
      int n;
      bit flag;

      // Reset values.
      i_rst = 1'b1;
      i_sdr_ctrl_scl_idle = 1'b1;
      i_timer_cas = 1'b0;
      i_scl_gen_stall = 1'b0;
      i_bitcnt_en = 1'b0;
      i_cccnt_err_rst = 1'b0;
      i_fcnt_en = 1'b0;
      i_sdr_scl_gen_pp_od = 1'b1;
      i_regf_CMD_ATTR = 1'b0;
      i_regf_DATA_LEN = 16'd0;
      i_regf_DTT = 3'd0;
      i_direct_broadcast_n = 1'b1;
      tick();
      tick();
      checkOutput("rst_scl", int'(o_scl), 1);
      checkOutput("rst_pos", int'(o_scl_pos_edge), 0);
      checkOutput("rst_neg", int'(o_scl_neg_edge), 0);
      checkOutput("rst_bitcnt", int'(o_cnt_bit_count), 0);
      checkOutput("rst_toggle", int'(o_frcnt_toggle), 0);
      checkOutput("rst_last", int'(o_cccnt_last_frame), 0);
      i_rst = 1'b0;
      tick();

      // Push-pull waveform, edge pulses and bit count across one frame.
      applyStimulus(1'b1, 1'b0, 16'd0, 3'd0, 1'b1, 1'b0);
      for (int c = 1; c <= 40; c++) begin
         tick();
         if (c < 2) begin
            checkOutput("pp_scl", int'(o_scl), 1);
            checkOutput("pp_neg", int'(o_scl_neg_edge), 0);
            checkOutput("pp_bitcnt", int'(o_cnt_bit_count), 0);
         end else begin
            m = (c - 2) % 4;
            n = (c - 2) / 4 + 1;
            checkOutput("pp_scl", int'(o_scl), (m < 2) ? 0 : 1);
            checkOutput("pp_neg", int'(o_scl_neg_edge), (m == 0) ? 1 : 0);
            checkOutput("pp_pos", int'(o_scl_pos_edge), (m == 2) ? 1 : 0);
            checkOutput("pp_bitcnt", int'(o_cnt_bit_count), n % 9);
            checkOutput("pp_toggle", int'(o_frcnt_toggle), (m == 0 && n % 9 == 0) ? 1 : 0);
         end
      end

      // Open-drain: 2 high, 6 low.
      applyStimulus(1'b0, 1'b0, 16'd0, 3'd0, 1'b1, 1'b0);
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (c == 2)  checkOutput("od_neg1", int'(o_scl_neg_edge), 1);
         if (c == 7)  checkOutput("od_low", int'(o_scl), 0);
         if (c == 8)  checkOutput("od_pos", int'(o_scl_pos_edge), 1);
         if (c == 8)  checkOutput("od_high", int'(o_scl), 1);
         if (c == 10) checkOutput("od_neg2", int'(o_scl_neg_edge), 1);
         if (c == 10) checkOutput("od_bitcnt", int'(o_cnt_bit_count), 2);
      end

      // Mode switch during a push-pull low phase: that phase keeps PP length.
      applyStimulus(1'b1, 1'b0, 16'd0, 3'd0, 1'b1, 1'b0);
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (c == 3) i_sdr_scl_gen_pp_od = 1'b0;
         if (c == 4)  checkOutput("sw_pos", int'(o_scl_pos_edge), 1);
         if (c == 6)  checkOutput("sw_neg", int'(o_scl_neg_edge), 1);
         if (c == 8)  checkOutput("sw_od_low", int'(o_scl), 0);
         if (c == 11) checkOutput("sw_od_low2", int'(o_scl), 0);
         if (c == 12) checkOutput("sw_od_pos", int'(o_scl_pos_edge), 1);
      end

      // CAS forces SCL high; release restarts with a full high phase.
      applyStimulus(1'b1, 1'b0, 16'd0, 3'd0, 1'b1, 1'b0);
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (c == 3) begin
            checkOutput("cas_pre_scl", int'(o_scl), 0);
            i_timer_cas = 1'b1;
         end
         if (c == 4) checkOutput("cas_scl", int'(o_scl), 1);
         if (c == 5) checkOutput("cas_bitcnt", int'(o_cnt_bit_count), 1);
         if (c == 6) i_timer_cas = 1'b0;
         if (c == 7) checkOutput("cas_hold_high", int'(o_scl), 1);
         if (c == 7) checkOutput("cas_no_neg", int'(o_scl_neg_edge), 0);
         if (c == 8) checkOutput("cas_neg", int'(o_scl_neg_edge), 1);
         if (c == 8) checkOutput("cas_bitcnt2", int'(o_cnt_bit_count), 2);
      end

      // Error clear at bit 5, then asynchronous reset mid-frame.
      applyStimulus(1'b1, 1'b0, 16'd0, 3'd0, 1'b1, 1'b0);
      flag = 1'b0;
      for (int c = 1; c <= 59; c++) begin
         tick();
         if (c == 18) begin
            checkOutput("err_pre", int'(o_cnt_bit_count), 5);
            i_cccnt_err_rst = 1'b1;
         end
         if (c == 19) begin
            checkOutput("err_clr", int'(o_cnt_bit_count), 0);
            i_cccnt_err_rst = 1'b0;
         end
         if (c == 22) checkOutput("err_restart", int'(o_cnt_bit_count), 1);
         if (c >= 19 && c <= 53 && o_frcnt_toggle) flag = 1'b1;
         if (c == 54) checkOutput("err_toggle", int'(o_frcnt_toggle), 1);
      end
      checkOutput("err_no_toggle", int'(flag), 0);
      checkOutput("mid_bitcnt", int'(o_cnt_bit_count), 1);
      i_rst = 1'b1;
      #1;
      checkOutput("mid_rst_scl", int'(o_scl), 1);
      checkOutput("mid_rst_bitcnt", int'(o_cnt_bit_count), 0);
      checkOutput("mid_rst_neg", int'(o_scl_neg_edge), 0);
      tick();
      i_rst = 1'b0;

      // Stall held for 10 clocks, starting right after a rising edge.
      applyStimulus(1'b1, 1'b0, 16'd0, 3'd0, 1'b1, 1'b0);
      for (int c = 1; c <= 20; c++) tick();
      checkOutput("stall_pre_pos", int'(o_scl_pos_edge), 1);
      checkOutput("stall_pre_bitcnt", int'(o_cnt_bit_count), 5);
      i_scl_gen_stall = 1'b1;
      flag = 1'b0;
      for (int c = 21; c <= 30; c++) begin
         tick();
         if (o_scl_pos_edge || o_scl_neg_edge) flag = 1'b1;
      end
`ifdef SCL_STALL_EN
      checkOutput("stall_edges", int'(flag), 0);
      checkOutput("stall_scl", int'(o_scl), 1);
      checkOutput("stall_bitcnt", int'(o_cnt_bit_count), 5);
      i_scl_gen_stall = 1'b0;
      tick();
      checkOutput("stall_rel_scl", int'(o_scl), 1);
      tick();
      checkOutput("stall_rel_neg", int'(o_scl_neg_edge), 1);
      checkOutput("stall_rel_bitcnt", int'(o_cnt_bit_count), 6);
`else
      checkOutput("nostall_edges", int'(flag), 1);
      checkOutput("nostall_neg", int'(o_scl_neg_edge), 1);
      checkOutput("nostall_bitcnt", int'(o_cnt_bit_count), 8);
      i_scl_gen_stall = 1'b0;
      tick();
      checkOutput("nostall_scl", int'(o_scl), 0);
      tick();
      checkOutput("nostall_pos", int'(o_scl_pos_edge), 1);
`endif

      // Frame counting scenarios.
      runFrames("reg2_bcast", 1'b0, 16'd2, 3'd0, 1'b0, 3);
      runFrames("reg5_direct", 1'b0, 16'd5, 3'd0, 1'b1, 5);
      runFrames("reg0_bcast", 1'b0, 16'd0, 3'd0, 1'b0, 1);
      for (int i = 0; i < 8; i++) begin
         runFrames($sformatf("imm_dir_dtt%0d", i), 1'b1, 16'd9, dttList[i], 1'b1, nDirect[i]);
      end
      for (int i = 0; i < 8; i++) begin
         runFrames($sformatf("imm_bc_dtt%0d", i), 1'b1, 16'd9, dttList[i], 1'b0, nBcast[i]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
      $finish;
   end

endmodule
